// File: rtl/mult_seq_shift_add.sv
// Sequential shift-add multiplier, one iteration per clock, with a start/busy/done handshake.
// Signed mode multiplies magnitudes and negates the final product.
module mult_seq_shift_add #(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           sgn,
    input  logic [W-1:0]   X,
    input  logic [W-1:0]   Y,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] P
);

    localparam int unsigned CW = $clog2(W + 1);
    localparam logic [CW-1:0] CntInit = CW'(W);
    localparam logic [CW-1:0] CntLast = CW'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state;
    logic [W-1:0]     mcand;
    logic [W-1:0]     mplier;
    logic             neg;
    logic [2*W-1:0]   acc;
    logic [CW-1:0]    cnt;

    logic [W-1:0]     x_mag;
    logic [W-1:0]     y_mag;
    logic [W:0]       sum;
    logic [2*W-1:0]   acc_nxt;
    logic [2*W-1:0]   prod_nxt;

    always_comb begin
        // Negating -2^(W-1) wraps to 2^(W-1), which is the correct unsigned magnitude.
        x_mag    = (sgn && X[W-1]) ? (~X + W'(1)) : X;
        y_mag    = (sgn && Y[W-1]) ? (~Y + W'(1)) : Y;
        sum      = {1'b0, acc[2*W-1:W]} + {1'b0, (mplier[0] ? mcand : '0)};
        acc_nxt  = {sum, acc[W-1:1]};
        prod_nxt = neg ? (~acc_nxt + (2*W)'(1)) : acc_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= StIdle;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            P      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= x_mag;
                        mplier <= y_mag;
                        neg    <= sgn & (X[W-1] ^ Y[W-1]);
                        acc    <= '0;
                        cnt    <= CntInit;
                        busy   <= 1'b1;
                        state  <= StRun;
                    end
                end
                StRun: begin
                    acc    <= acc_nxt;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CntLast) begin
                        P     <= prod_nxt;
                        done  <= 1'b1;
                        state <= StDone;
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_shift_add.sv
// Self-checking bench for mult_seq_shift_add: directed vectors, exhaustive W=3, random W=8,
// and multi-cycle handshake corner cases.
module tb_mult_seq_shift_add;

    logic clk;
    logic rst;

    logic        start8, sgn8, busy8, done8;
    logic [7:0]  x8, y8;
    logic [15:0] p8;

    logic        start3, sgn3, busy3, done3;
    logic [2:0]  x3, y3;
    logic [5:0]  p3;

    int checks = 0;
    int errors = 0;

    mult_seq_shift_add #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sgn(sgn8), .X(x8), .Y(y8),
        .busy(busy8), .done(done8), .P(p8)
    );

    mult_seq_shift_add #(.W(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .sgn(sgn3), .X(x3), .Y(y3),
        .busy(busy3), .done(done3), .P(p3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        sgn;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] p;
        string       name;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h req=%0h", name, act, exp);
        end
    endtask

    // Product from plain integer arithmetic, truncated to 2*w bits.
    function automatic logic [63:0] ref_mul(input logic s, input logic [63:0] x,
                                            input logic [63:0] y, input int w);
        longint a, b;
        a = longint'(x);
        b = longint'(y);
        if (s && x[w-1]) a = a - (longint'(1) << w);
        if (s && y[w-1]) b = b - (longint'(1) << w);
        return 64'(a * b) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic wait_done8(output int k);
        k = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done8) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic run8(input logic s, input logic [7:0] x, input logic [7:0] y,
                        output logic [15:0] p);
        int k;
        @(negedge clk);
        sgn8 = s; x8 = x; y8 = y; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        x8 = 8'($urandom); y8 = 8'($urandom); sgn8 = 1'($urandom);
        check("busy8_after_start", 64'(busy8), 64'd1);
        wait_done8(k);
        check("latency8", 64'(k), 64'd8);
        p = p8;
        @(posedge clk); #1;
        check("done8_pulse", 64'(done8), 64'd0);
        check("busy8_idle", 64'(busy8), 64'd0);
    endtask

    task automatic run3(input logic s, input logic [2:0] x, input logic [2:0] y,
                        output logic [5:0] p);
        int k;
        @(negedge clk);
        sgn3 = s; x3 = x; y3 = y; start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        x3 = 3'($urandom); y3 = 3'($urandom);
        k = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done3) begin
                k = i;
                break;
            end
        end
        check("latency3", 64'(k), 64'd3);
        p = p3;
        @(posedge clk); #1;
        check("done3_pulse", 64'(done3), 64'd0);
    endtask

    initial begin
        logic [15:0] p;
        logic [5:0]  q;
        logic [63:0] cur, nxt;
        logic        rs;
        logic [7:0]  rx, ry;
        int          ndone;
        logic [15:0] pcap;

        tbl[0] = '{1'b0, 8'd255, 8'd255, 16'hFE01, "u_255x255"};
        tbl[1] = '{1'b1, 8'h80,  8'h80,  16'h4000, "s_m128xm128"};
        tbl[2] = '{1'b1, 8'h80,  8'h7F,  16'hC080, "s_m128x127"};
        tbl[3] = '{1'b1, 8'hFF,  8'h01,  16'hFFFF, "s_m1x1"};
        tbl[4] = '{1'b0, 8'd0,   8'd200, 16'h0000, "u_zero"};
        tbl[5] = '{1'b0, 8'd3,   8'd5,   16'd15,   "u_3x5"};
        tbl[6] = '{1'b0, 8'hFF,  8'h80,  16'h7F80, "u_255x128"};

        rst = 1'b1;
        start8 = 1'b0; sgn8 = 1'b0; x8 = '0; y8 = '0;
        start3 = 1'b0; sgn3 = 1'b0; x3 = '0; y3 = '0;
        #1;
        check("reset_busy8", 64'(busy8), 64'd0);
        check("reset_done8", 64'(done8), 64'd0);
        check("reset_p8", 64'(p8), 64'd0);
        check("reset_p3", 64'(p3), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            run8(tbl[i].sgn, tbl[i].x, tbl[i].y, p);
            check(tbl[i].name, 64'(p), 64'(tbl[i].p));
        end

        // Exhaustive W=3, unsigned and signed.
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 8; a++)
                for (int b = 0; b < 8; b++) begin
                    run3(1'(s), 3'(a), 3'(b), q);
                    check(s ? "w3_signed" : "w3_unsigned", 64'(q),
                          ref_mul(1'(s), 64'(a), 64'(b), 3));
                end

        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom); rx = 8'($urandom); ry = 8'($urandom);
            run8(rs, rx, ry, p);
            check("random8", 64'(p), ref_mul(rs, 64'(rx), 64'(ry), 8));
        end

        // Start pulsed mid-RUN must be ignored.
        @(negedge clk);
        sgn8 = 1'b0; x8 = 8'd10; y8 = 8'd20; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        x8 = 8'd7; y8 = 8'd9; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        ndone = 0;
        pcap = '0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done8) begin
                ndone++;
                pcap = p8;
            end
        end
        check("midrun_start_ndone", 64'(ndone), 64'd1);
        check("midrun_start_p", 64'(pcap), 64'd200);

        // Async reset in the middle of RUN.
        @(negedge clk);
        sgn8 = 1'b0; x8 = 8'd100; y8 = 8'd50; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        check("pre_rst_busy8", 64'(busy8), 64'd1);
        rst = 1'b1;
        #1;
        check("async_rst_busy8", 64'(busy8), 64'd0);
        check("async_rst_done8", 64'(done8), 64'd0);
        check("async_rst_p8", 64'(p8), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run8(1'b0, 8'd3, 8'd5, p);
        check("post_rst_3x5", 64'(p), 64'd15);

        // Start held high: one result every W+2 cycles, each from its own start edge.
        @(negedge clk);
        sgn8 = 1'($urandom); x8 = 8'($urandom); y8 = 8'($urandom); start8 = 1'b1;
        cur = ref_mul(sgn8, 64'(x8), 64'(y8), 8);
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            check("held_busy", 64'(busy8), 64'd1);
            sgn8 = 1'($urandom); x8 = 8'($urandom); y8 = 8'($urandom);
            nxt = ref_mul(sgn8, 64'(x8), 64'(y8), 8);
            repeat (7) @(posedge clk);
            #1;
            check("held_done_early", 64'(done8), 64'd0);
            @(posedge clk); #1;
            check("held_done", 64'(done8), 64'd1);
            check("held_p", 64'(p8), cur);
            @(posedge clk); #1;
            check("held_done_low", 64'(done8), 64'd0);
            check("held_idle", 64'(busy8), 64'd0);
            cur = nxt;
        end
        start8 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
